lap_stopwatch: RTL and testbench

Parametrised stopwatch/countdown timer with pause/resume, lap capture and a small lap FIFO. A prescaler divides the system clock into time units. A unit counter counts up from zero, or down from a loaded value with an expiry flag. Lap snapshots are buffered for a display or readout block to pop. It replaces the fixed-width, count-up-only stopwatch in board top levels.

---
 rtl/lap_stopwatch_pkg.sv | 17 +
 rtl/lap_fifo.sv | 92 +++++++++
 rtl/lap_stopwatch.sv | 131 +++++++++++++
 tb/tb_lap_stopwatch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_stopwatch_pkg.sv
// Shared constants for the lap stopwatch: FSM state encodings and count-mode values.
package lap_stopwatch_pkg;

   localparam logic [1:0] ST_IDLE     = 2'b00;
   localparam logic [1:0] ST_COUNTING = 2'b01;
   localparam logic [1:0] ST_PAUSED   = 2'b10;
   localparam logic [1:0] ST_EXPIRED  = 2'b11;

   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;

   // Laps are accepted in every state except IDLE.
   function automatic logic lap_allowed(input logic [1:0] state);
      return state != ST_IDLE;
   endfunction

endpackage

// File: rtl/lap_fifo.sv
// Small synchronous FIFO for lap snapshots with a registered head, flush and sticky overflow.
module lap_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic             clk,
   input  logic             async_reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] rd_q, rd_n, wr_q, wr_n, rd_inc_c;
   logic [CW-1:0]         count_q, count_n;
   logic [WIDTH-1:0]      head_q, head_n;
   logic                  empty_q, full_q, ovf_q, ovf_n;
   logic                  do_push_c, do_pop_c;

   assign do_pop_c  = pop && !empty_q && !flush;
   assign do_push_c = push && (!full_q || do_pop_c) && !flush;
   assign rd_inc_c  = rd_q + 1'b1;

   // Next pointers, occupancy and head; the head is kept registered so lap_data is a flop.
   always_comb begin
      rd_n    = rd_q;
      wr_n    = wr_q;
      count_n = count_q;
      head_n  = head_q;
      ovf_n   = ovf_q;
      if (flush) begin
         rd_n    = '0;
         wr_n    = '0;
         count_n = '0;
         head_n  = '0;
         ovf_n   = 1'b0;
      end else begin
         if (do_push_c) wr_n = wr_q + 1'b1;
         if (do_pop_c)  rd_n = rd_inc_c;
         case ({do_push_c, do_pop_c})
            2'b10:   count_n = count_q + 1'b1;
            2'b01:   count_n = count_q - 1'b1;
            default: count_n = count_q;
         endcase
         if (do_pop_c) begin
            if (count_q > CW'(1))  head_n = mem_q[rd_inc_c];
            else if (do_push_c)    head_n = push_data;
         end else if (do_push_c && empty_q) begin
            head_n = push_data;
         end
         if (push && full_q && !do_pop_c) ovf_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         rd_q    <= rd_n;
         wr_q    <= wr_n;
         count_q <= count_n;
         head_q  <= head_n;
         empty_q <= (count_n == '0);
         full_q  <= (count_n == CW'(DEPTH));
         ovf_q   <= ovf_n;
      end
   end

   assign head     = head_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch / countdown timer: prescaler, unit counter and control FSM, plus a lap FIFO.
module lap_stopwatch
   import lap_stopwatch_pkg::*;
#(
   parameter int unsigned TICKS_PER_UNIT = 50_000_000,
   parameter int unsigned TICK_WIDTH     = 28,
   parameter int unsigned UNIT_WIDTH     = 8,
   parameter int unsigned LAP_DEPTH      = 4,
   parameter int unsigned LAP_ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  async_reset,
   input  logic                  start_pause,
   input  logic                  lap,
   input  logic                  clear,
   input  logic                  count_down,
   input  logic [UNIT_WIDTH-1:0] load_value,
   input  logic                  lap_pop,
   output logic [UNIT_WIDTH-1:0] value,
   output logic                  running,
   output logic                  expired,
   output logic [UNIT_WIDTH-1:0] lap_data,
   output logic                  lap_empty,
   output logic                  lap_full,
   output logic                  lap_overflow
);

   localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICKS_PER_UNIT - 1);

   logic [1:0]            state_q, state_n;
   logic                  mode_q, mode_n;
   logic [UNIT_WIDTH-1:0] value_q, value_n;
   logic [TICK_WIDTH-1:0] presc_q, presc_n;
   logic                  running_q, expired_q;
   logic                  tick_c, lap_push_c;

   assign tick_c     = (state_q == ST_COUNTING) && (presc_q == TICK_LAST);
   assign lap_push_c = lap && lap_allowed(state_q);

   // Next state, prescaler and value; a tick in the same cycle as start_pause is applied first.
   always_comb begin
      state_n = state_q;
      mode_n  = mode_q;
      value_n = value_q;
      presc_n = presc_q;
      if (clear) begin
         state_n = ST_IDLE;
         value_n = '0;
         presc_n = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_pause) begin
                  mode_n  = count_down ? MODE_DOWN : MODE_UP;
                  presc_n = '0;
                  if (count_down && (load_value == '0)) begin
                     state_n = ST_EXPIRED;
                     value_n = '0;
                  end else begin
                     state_n = ST_COUNTING;
                     value_n = count_down ? load_value : '0;
                  end
               end
            end
            ST_COUNTING: begin
               presc_n = tick_c ? '0 : presc_q + 1'b1;
               if (tick_c) begin
                  if (mode_q == MODE_UP) begin
                     value_n = value_q + 1'b1;
                  end else begin
                     value_n = value_q - 1'b1;
                     if (value_q == UNIT_WIDTH'(1)) state_n = ST_EXPIRED;
                  end
               end
               if (start_pause && (state_n == ST_COUNTING)) state_n = ST_PAUSED;
            end
            ST_PAUSED: begin
               if (start_pause) state_n = ST_COUNTING;
            end
            ST_EXPIRED: begin
               value_n = '0;
            end
            default: begin
               state_n = ST_IDLE;
               value_n = '0;
               presc_n = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_UP;
         value_q   <= '0;
         presc_q   <= '0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         mode_q    <= mode_n;
         value_q   <= value_n;
         presc_q   <= presc_n;
         running_q <= (state_n == ST_COUNTING);
         expired_q <= (state_n == ST_EXPIRED);
      end
   end

   lap_fifo #(
      .WIDTH      (UNIT_WIDTH),
      .DEPTH      (LAP_DEPTH),
      .ADDR_WIDTH (LAP_ADDR_WIDTH)
   ) u_lap_fifo (
      .clk         (clk),
      .async_reset (async_reset),
      .flush       (clear),
      .push        (lap_push_c),
      .push_data   (value_q),
      .pop         (lap_pop),
      .head        (lap_data),
      .empty       (lap_empty),
      .full        (lap_full),
      .overflow    (lap_overflow)
   );

   assign value   = value_q;
   assign running = running_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: directed scenarios and random stimulus against an elapsed-time model.
module tb_lap_stopwatch;

   localparam int TPU = 4;
   localparam int DEP = 4;

   logic       clk = 1'b0;
   logic       async_reset, start_pause, lap, clear, count_down, lap_pop;
   logic [3:0] load_value;
   logic [3:0] value, lap_data;
   logic       running, expired, lap_empty, lap_full, lap_overflow;
   logic [8:0] obs;

   int total = 0;
   int bad   = 0;

   // Model: phase 0 idle, 1 counting, 2 paused, 3 expired; value derived from elapsed cycles.
   int m_phase, m_elapsed, m_load;
   bit m_down, m_ovf;
   int m_q[$];

   always #5 clk = ~clk;

   lap_stopwatch #(
      .TICKS_PER_UNIT (TPU),
      .TICK_WIDTH     (3),
      .UNIT_WIDTH     (4),
      .LAP_DEPTH      (DEP),
      .LAP_ADDR_WIDTH (2)
   ) dut (
      .clk          (clk),
      .async_reset  (async_reset),
      .start_pause  (start_pause),
      .lap          (lap),
      .clear        (clear),
      .count_down   (count_down),
      .load_value   (load_value),
      .lap_pop      (lap_pop),
      .value        (value),
      .running      (running),
      .expired      (expired),
      .lap_data     (lap_data),
      .lap_empty    (lap_empty),
      .lap_full     (lap_full),
      .lap_overflow (lap_overflow)
   );

   assign obs = {value, running, expired, lap_empty, lap_full, lap_overflow};

   function automatic int exp_value();
      if (m_phase == 0 || m_phase == 3) return 0;
      if (m_down) return m_load - m_elapsed / TPU;
      return (m_elapsed / TPU) % 16;
   endfunction

   function automatic logic [8:0] exp_vec();
      return {4'(exp_value()), m_phase == 1, m_phase == 3, m_q.size() == 0,
              m_q.size() == DEP, m_ovf};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_elapsed = 0; m_load = 0; m_down = 0; m_ovf = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      int pre;
      if (clear) begin
         model_reset();
         return;
      end
      pre = exp_value();
      if (lap_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (lap && m_phase != 0) begin
         if (m_q.size() < DEP) m_q.push_back(pre);
         else m_ovf = 1;
      end
      case (m_phase)
         0: if (start_pause) begin
               m_down = count_down; m_load = int'(load_value); m_elapsed = 0;
               m_phase = (count_down && load_value == 0) ? 3 : 1;
            end
         1: begin
               m_elapsed++;
               if (m_down && (m_load - m_elapsed / TPU) <= 0) m_phase = 3;
               else if (start_pause) m_phase = 2;
            end
         2: if (start_pause) m_phase = 1;
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      start_pause = 0; lap = 0; clear = 0; lap_pop = 0;
   endtask

   task automatic test_reset();
      #23;
      total++; if (value !== 4'd0) begin bad++; $display("FAIL reset_value: got %0d want 0", value); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %0b want 0", running); end
      total++; if (expired !== 1'b0) begin bad++; $display("FAIL reset_expired: got %0b want 0", expired); end
      total++; if (lap_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", lap_empty); end
      total++; if (lap_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", lap_full); end
      total++; if (lap_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", lap_overflow); end
      total++; if (lap_data !== 4'd0) begin bad++; $display("FAIL reset_lap_data: got %0d want 0", lap_data); end
      @(negedge clk);
      async_reset = 1;
      model_reset();
   endtask

   task automatic test_up_pause();
      count_down = 0; start_pause = 1; step();
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL up_start: got %h want %h", obs, exp_vec()); end
      for (int i = 1; i <= 12; i++) begin
         step();
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL up_run[%0d]: got %h want %h", i, obs, exp_vec()); end
         if (i == 4) begin
            total++; if (value !== 4'd1) begin bad++; $display("FAIL up_first_tick: got %0d want 1", value); end
         end
         if (i == 12) begin
            total++; if (value !== 4'd3) begin bad++; $display("FAIL up_third_tick: got %0d want 3", value); end
         end
      end
      step();
      start_pause = 1; step();
      total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running: got %0b want 0", running); end
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (value !== 4'd3 || obs !== exp_vec()) begin bad++; $display("FAIL pause_hold[%0d]: got %0d want 3", i, value); end
      end
      start_pause = 1; step();
      total++; if (running !== 1'b1 || value !== 4'd3) begin bad++; $display("FAIL resume: got run=%0b val=%0d want run=1 val=3", running, value); end
      step();
      total++; if (value !== 4'd3) begin bad++; $display("FAIL resume_partial1: got %0d want 3", value); end
      step();
      total++; if (value !== 4'd4) begin bad++; $display("FAIL resume_partial2: got %0d want 4", value); end
   endtask

   task automatic test_wrap();
      bit saw_wrap;
      logic [3:0] prev;
      saw_wrap = 0;
      clear = 1; step();
      count_down = 0; start_pause = 1; step();
      prev = value;
      for (int i = 0; i < 16 * TPU; i++) begin
         step();
         total++; if (obs !== exp_vec() || running !== 1'b1) begin bad++; $display("FAIL wrap_run[%0d]: got %h want %h", i, obs, exp_vec()); end
         if (prev == 4'd15 && value == 4'd0) saw_wrap = 1;
         prev = value;
      end
      total++; if (saw_wrap !== 1'b1) begin bad++; $display("FAIL wrap_seen: got %0b want 1", saw_wrap); end
   endtask

   task automatic test_countdown();
      clear = 1; step();
      count_down = 1; load_value = 4'd3; start_pause = 1; step();
      total++; if (value !== 4'd3 || running !== 1'b1) begin bad++; $display("FAIL cd_load: got %0d want 3", value); end
      for (int i = 1; i <= 12; i++) begin
         step();
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL cd_run[%0d]: got %h want %h", i, obs, exp_vec()); end
         if (i == 4 || i == 8) begin
            total++; if (value !== 4'(3 - i / 4)) begin bad++; $display("FAIL cd_tick[%0d]: got %0d want %0d", i, value, 3 - i / 4); end
         end
         if (i == 11) begin
            total++; if (running !== 1'b1 || expired !== 1'b0) begin bad++; $display("FAIL cd_pre_expire: got run=%0b exp=%0b want 1 0", running, expired); end
         end
      end
      total++; if (value !== 4'd0 || expired !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL cd_expire: got val=%0d exp=%0b run=%0b want 0 1 0", value, expired, running); end
      start_pause = 1; step();
      total++; if (expired !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL cd_sp_ignored: got exp=%0b run=%0b want 1 0", expired, running); end
      clear = 1; step();
      load_value = 4'd0; start_pause = 1; step();
      total++; if (expired !== 1'b1 || running !== 1'b0 || value !== 4'd0) begin bad++; $display("FAIL cd_zero_load: got exp=%0b run=%0b want 1 0", expired, running); end
      count_down = 0;
   endtask

   task automatic test_lap_fifo();
      int want[5];
      clear = 1; step();
      start_pause = 1; step();
      repeat (5) step();
      for (int k = 0; k < 5; k++) begin
         want[k] = exp_value();
         lap = 1; step();
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL lap_push[%0d]: got %h want %h", k, obs, exp_vec()); end
      end
      total++; if (lap_full !== 1'b1 || lap_overflow !== 1'b1) begin bad++; $display("FAIL lap_full_ovf: got full=%0b ovf=%0b want 1 1", lap_full, lap_overflow); end
      for (int k = 0; k < 4; k++) begin
         total++; if (lap_data !== 4'(want[k])) begin bad++; $display("FAIL lap_pop_data[%0d]: got %0d want %0d", k, lap_data, want[k]); end
         lap_pop = 1; step();
      end
      total++; if (lap_empty !== 1'b1 || lap_overflow !== 1'b1) begin bad++; $display("FAIL lap_drained: got empty=%0b ovf=%0b want 1 1", lap_empty, lap_overflow); end
      lap_pop = 1; step();
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL lap_pop_empty: got %h want %h", obs, exp_vec()); end
      clear = 1; step();
      start_pause = 1; step();
      repeat (4) begin lap = 1; step(); step(); end
      lap = 1; lap_pop = 1; step();
      total++; if (lap_overflow !== 1'b0 || lap_full !== 1'b1 || obs !== exp_vec()) begin bad++; $display("FAIL lap_push_pop_full: got %h want %h", obs, exp_vec()); end
      total++; if (lap_data !== 4'(m_q[0])) begin bad++; $display("FAIL lap_push_pop_head: got %0d want %0d", lap_data, m_q[0]); end
   endtask

   task automatic test_priority();
      lap = 1; step();
      total++; if (lap_overflow !== 1'b1) begin bad++; $display("FAIL prio_setup_ovf: got %0b want 1", lap_overflow); end
      clear = 1; start_pause = 1; lap = 1; step();
      total++; if (running !== 1'b0 || value !== 4'd0 || lap_empty !== 1'b1 || lap_overflow !== 1'b0 || expired !== 1'b0)
         begin bad++; $display("FAIL prio_clear: got %h want %h", obs, 9'b0000_0_0_1_0_0); end
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL prio_model: got %h want %h", obs, exp_vec()); end
   endtask

   task automatic test_lap_tick();
      int pre;
      count_down = 0; start_pause = 1; step();
      repeat (5) step();
      for (int i = 0; i < 2 * TPU; i++) begin
         if (m_elapsed % TPU == TPU - 1) break;
         step();
      end
      pre = exp_value();
      lap = 1; step();
      total++; if (lap_data !== 4'(pre) || lap_empty !== 1'b0) begin bad++; $display("FAIL lap_tick_data: got %0d want %0d", lap_data, pre); end
      total++; if (value !== 4'(pre + 1)) begin bad++; $display("FAIL lap_tick_value: got %0d want %0d", value, pre + 1); end
   endtask

   task automatic test_random();
      clear = 1; step();
      for (int i = 0; i < 600; i++) begin
         start_pause = ($urandom_range(0, 7) == 0);
         lap         = ($urandom_range(0, 3) == 0);
         lap_pop     = ($urandom_range(0, 4) == 0);
         clear       = ($urandom_range(0, 59) == 0);
         count_down  = 1'($urandom_range(0, 1));
         load_value  = 4'($urandom_range(0, 15));
         step();
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rand_vec[%0d]: got %h want %h", i, obs, exp_vec()); end
         if (m_q.size() > 0) begin
            total++; if (lap_data !== 4'(m_q[0])) begin bad++; $display("FAIL rand_head[%0d]: got %0d want %0d", i, lap_data, m_q[0]); end
         end
      end
      count_down = 0;
   endtask

   task automatic test_reset_mid();
      clear = 1; step();
      count_down = 0; start_pause = 1; step();
      repeat (5) step();
      lap = 1; step();
      #2 async_reset = 0;
      #1;
      total++; if (value !== 4'd0 || running !== 1'b0 || expired !== 1'b0) begin bad++; $display("FAIL rst_mid_count: got val=%0d run=%0b want 0 0", value, running); end
      total++; if (lap_empty !== 1'b1 || lap_full !== 1'b0 || lap_overflow !== 1'b0 || lap_data !== 4'd0)
         begin bad++; $display("FAIL rst_mid_fifo: got empty=%0b data=%0d want 1 0", lap_empty, lap_data); end
      @(negedge clk);
      async_reset = 1;
      model_reset();
      start_pause = 1; step();
      for (int i = 1; i <= TPU; i++) begin
         step();
         total++; if (value !== ((i == TPU) ? 4'd1 : 4'd0) || obs !== exp_vec())
            begin bad++; $display("FAIL rst_first_tick[%0d]: got %0d want %0d", i, value, (i == TPU) ? 1 : 0); end
      end
   endtask

   initial begin
      async_reset = 0; start_pause = 0; lap = 0; clear = 0;
      count_down = 0; load_value = 4'd0; lap_pop = 0;
      model_reset();
      test_reset();
      test_up_pause();
      test_wrap();
      test_countdown();
      test_lap_fifo();
      test_priority();
      test_lap_tick();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
